mux41_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the 4:1 mux (m41) between four requesters. It drives the mux select pair S1/S0 and returns a one-hot grant, so only the granted source's data appears on Y. A hold limit stops one requester from keeping the mux while others wait. It sits directly in front of m41; sel[1] feeds S1 and sel[0] feeds S0.

---
 rtl/mux41_arb_pkg.sv | 26 ++
 rtl/mux41_rr_arbiter_rr_pick.sv | 39 +++
 rtl/mux41_rr_arbiter.sv | 151 +++++++++++++++
 tb/tb_mux41_rr_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mux41_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux41_arb_pkg
//  Description : Shared types, constants and helpers for the round-robin
//                arbiter that drives the select pair of the 4:1 mux (m41).
//  Contents    : NUM_REQ / SEL_W constants, arbiter state enum, onehot().
//  Revision    : 1.0 - initial release
// ============================================================================
package mux41_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // One-hot decode of a requester index.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage : mux41_arb_pkg
`default_nettype wire

// File: rtl/mux41_rr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin selector. Scans indices
//                last_ptr+1 .. last_ptr+4 (mod 4) and returns the first one
//                with its request bit set. last_ptr itself is scanned last.
//  Ports       : req_i       [3:0] request vector
//                last_ptr_i  [1:0] index of the most recent grant
//                pick_o      [1:0] winning index (valid when any_valid_o)
//                any_valid_o       at least one request bit is set
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import mux41_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SEL_W-1:0]   last_ptr_i,
  output logic [SEL_W-1:0]   pick_o,
  output logic               any_valid_o
);

  logic [SEL_W-1:0] idx;

  // Walk the scan order backwards so the closest candidate is assigned last
  // and therefore wins. The SEL_W-bit add provides the mod-4 wrap.
  always_comb begin
    pick_o      = last_ptr_i;
    any_valid_o = |req_i;
    idx         = last_ptr_i;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = last_ptr_i + SEL_W'(k);
      if (req_i[idx]) begin
        pick_o = idx;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/mux41_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mux41_rr_arbiter
//  Description : Round-robin arbiter sharing the m41 4:1 mux between four
//                requesters, with a hold limit that rotates the grant away
//                from an owner that has kept it MAX_HOLD cycles while others
//                wait.
//  Ports       : clk           clock, rising edge
//                rst_n         asynchronous active-low reset
//                req     [3:0] request vector, req[i] = source Di wants Y
//                gnt     [3:0] registered one-hot grant, zero when idle
//                sel     [1:0] registered {S1,S0} = owner index, to m41
//                busy          registered, equals |gnt
//                preempt       one-cycle pulse on a hold-limit rotation
//  Revision    : 1.0 - initial release
// ============================================================================
module mux41_rr_arbiter
  import mux41_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int NUM_REQ  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               preempt
);

  if (NUM_REQ != 4) begin : g_bad_num_req
    $error("mux41_rr_arbiter: NUM_REQ must be 4 to match m41");
  end

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("mux41_rr_arbiter: MAX_HOLD must be in 1..255");
  end

  localparam int               HOLD_W    = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_e               state_q,   state_d;
  logic [NUM_REQ-1:0]   gnt_q,     gnt_d;
  logic [SEL_W-1:0]     sel_q,     sel_d;
  logic                 busy_q,    busy_d;
  logic                 preempt_q, preempt_d;
  logic [HOLD_W-1:0]    hold_q,    hold_d;
  logic [SEL_W-1:0]     last_q,    last_d;

  logic [SEL_W-1:0]     pick;
  logic                 any_valid;
  logic                 owner_req;
  logic                 others_pending;
  logic                 do_grant;

  rr_pick u_rr_pick (
    .req_i       (req),
    .last_ptr_i  (last_q),
    .pick_o      (pick),
    .any_valid_o (any_valid)
  );

  // While granted, last_q equals the owner, so the owner is only picked when
  // nobody else is requesting.
  assign owner_req      = req[sel_q];
  assign others_pending = |(req & ~onehot(sel_q));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      sel_q     <= '0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
      hold_q    <= '0;
      last_q    <= 2'b11;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      preempt_q <= preempt_d;
      hold_q    <= hold_d;
      last_q    <= last_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    preempt_d = 1'b0;
    hold_d    = hold_q;
    last_d    = last_q;
    do_grant  = 1'b0;

    case (state_q)
      IDLE: begin
        do_grant = any_valid;
      end
      GRANT: begin
        if (!owner_req) begin
          // Release: hand over on the same edge if anyone else is waiting.
          if (any_valid) begin
            do_grant = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
            hold_d  = '0;
          end
        end else if (others_pending && hold_q == HOLD_LAST) begin
          do_grant  = 1'b1;
          preempt_d = 1'b1;
        end else if (hold_q != HOLD_LAST) begin
          // Counter saturates so late contention preempts on the next edge.
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        hold_d  = '0;
      end
    endcase

    if (do_grant) begin
      state_d = GRANT;
      gnt_d   = onehot(pick);
      sel_d   = pick;
      busy_d  = 1'b1;
      hold_d  = '0;
      last_d  = pick;
    end
  end

  // Output logic: every output comes straight from a register.
  always_comb begin
    gnt     = gnt_q;
    sel     = sel_q;
    busy    = busy_q;
    preempt = preempt_q;
  end

endmodule : mux41_rr_arbiter
`default_nettype wire

// File: tb/tb_mux41_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux41_rr_arbiter
//  Description : Self-checking bench for mux41_rr_arbiter. Two instances
//                (MAX_HOLD=8 and MAX_HOLD=1) share one request vector; the
//                MAX_HOLD=1 select drives a 4:1 mux with D0..D3 = 0,1,0,1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux41_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;

  logic [3:0] gnt8, gnt1;
  logic [1:0] sel8, sel1;
  logic       busy8, busy1, pre8, pre1;
  logic [3:0] dvec;
  logic       y1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux41_rr_arbiter #(.MAX_HOLD(8), .NUM_REQ(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt8), .sel(sel8), .busy(busy8), .preempt(pre8)
  );

  mux41_rr_arbiter #(.MAX_HOLD(1), .NUM_REQ(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt1), .sel(sel1), .busy(busy1), .preempt(pre1)
  );

  // m41 stand-in: Y = D[{S1,S0}], D0..D3 = 0,1,0,1
  assign dvec = 4'b1010;
  assign y1   = dvec[sel1];

  // Reference model: owner is -1 when idle.
  typedef struct {
    int owner;
    int last;
    int hold;
    bit pre;
    int selv;
  } mdl_t;

  mdl_t m8, m1;

  function automatic mdl_t model_reset();
    mdl_t s;
    s.owner = -1; s.last = 3; s.hold = 0; s.pre = 1'b0; s.selv = 0;
    return s;
  endfunction

  function automatic mdl_t model_step(mdl_t s, logic [3:0] r, int lim);
    mdl_t n;
    int   nxt;
    int   idx;
    bit   others;
    bit   take;
    n = s; n.pre = 1'b0; nxt = -1; others = 1'b0; take = 1'b0;
    for (int i = 0; i < 4; i++)
      if (r[i] && i != s.owner) others = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      idx = (s.last + k) % 4;
      if (nxt < 0 && r[idx]) nxt = idx;
    end
    if (s.owner < 0) begin
      take = (nxt >= 0);
    end else if (!r[s.owner]) begin
      if (nxt >= 0) take = 1'b1;
      else begin n.owner = -1; n.hold = 0; end
    end else if (others && s.hold == lim - 1) begin
      take = 1'b1; n.pre = 1'b1;
    end else if (s.hold < lim - 1) begin
      n.hold = s.hold + 1;
    end
    if (take) begin
      n.owner = nxt; n.last = nxt; n.selv = nxt; n.hold = 0;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("gnt8",  {28'd0, gnt8},  (m8.owner < 0) ? 32'd0 : (32'd1 << m8.owner));
    chk("sel8",  {30'd0, sel8},  m8.selv);
    chk("busy8", {31'd0, busy8}, (m8.owner >= 0) ? 32'd1 : 32'd0);
    chk("pre8",  {31'd0, pre8},  {31'd0, m8.pre});
    chk("gnt1",  {28'd0, gnt1},  (m1.owner < 0) ? 32'd0 : (32'd1 << m1.owner));
    chk("sel1",  {30'd0, sel1},  m1.selv);
    chk("busy1", {31'd0, busy1}, (m1.owner >= 0) ? 32'd1 : 32'd0);
    chk("pre1",  {31'd0, pre1},  {31'd0, m1.pre});
    chk("y1",    {31'd0, y1},    m1.selv % 2);
  endtask

  // Apply r for one clock edge, advance the model, then sample.
  task automatic cycle(input logic [3:0] r);
    req = r;
    @(posedge clk);
    m8 = model_step(m8, r, 8);
    m1 = model_step(m1, r, 1);
    #1;
    check_model();
  endtask

  // Assert reset mid-cycle, check outputs asynchronously, release on negedge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    m8 = model_reset();
    m1 = model_reset();
    check_model();
    chk("rst_gnt8",  {28'd0, gnt8},  32'h0);
    chk("rst_sel8",  {30'd0, sel8},  32'h0);
    chk("rst_busy8", {31'd0, busy8}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    m8 = model_reset();
    m1 = model_reset();
    repeat (2) @(negedge clk);
    check_model();
    rst_n = 1'b1;

    // Single request from idle, then release; sel keeps its value.
    cycle(4'b0100);
    chk("single_gnt",  {28'd0, gnt8},  32'h4);
    chk("single_sel",  {30'd0, sel8},  32'h2);
    chk("single_busy", {31'd0, busy8}, 32'h1);
    cycle(4'b0000);
    chk("release_gnt", {28'd0, gnt8},  32'h0);
    chk("release_sel", {30'd0, sel8},  32'h2);

    // Reset in the middle of a grant held by requester 2.
    cycle(4'b0100);
    cycle(4'b0100);
    do_reset();
    cycle(4'b1111);
    chk("post_rst_gnt", {28'd0, gnt8}, 32'h1);

    // Round robin: each owner drops after two cycles, no idle bubble.
    for (int k = 0; k < 4; k++) begin
      cycle(4'b1111);
      cycle(4'b1111 & ~(4'b0001 << k));
      chk("rr_gnt",  {28'd0, gnt8},  32'h1 << ((k + 1) % 4));
      chk("rr_busy", {31'd0, busy8}, 32'h1);
    end

    // Hold-limit preempt with two contenders; MAX_HOLD=1 mux output alternates.
    do_reset();
    for (int i = 0; i < 25; i++) begin
      cycle(4'b0011);
      chk("alt_y1", {31'd0, y1}, i % 2);
      if (i < 8) begin
        chk("hold_gnt", {28'd0, gnt8}, 32'h1);
        chk("hold_pre", {31'd0, pre8}, 32'h0);
      end else if (i == 8) begin
        chk("preempt_gnt", {28'd0, gnt8}, 32'h2);
        chk("preempt_pre", {31'd0, pre8}, 32'h1);
      end else if (i < 16) begin
        chk("hold2_gnt", {28'd0, gnt8}, 32'h2);
        chk("hold2_pre", {31'd0, pre8}, 32'h0);
      end else if (i == 16) begin
        chk("preempt2_gnt", {28'd0, gnt8}, 32'h1);
        chk("preempt2_pre", {31'd0, pre8}, 32'h1);
      end
    end

    // Uncontended saturation, then contention preempts on the next edge.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cycle(4'b1000);
      chk("sat_gnt", {28'd0, gnt8}, 32'h8);
      chk("sat_pre", {31'd0, pre8}, 32'h0);
    end
    cycle(4'b1001);
    chk("sat_preempt_gnt", {28'd0, gnt8}, 32'h1);
    chk("sat_preempt_pre", {31'd0, pre8}, 32'h1);

    // Randomised traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) do_reset();
      if ($urandom_range(0, 3) == 0)
        cycle(4'($urandom_range(0, 15)));
      else
        cycle(req);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mux41_rr_arbiter
`default_nettype wire
